// File: rtl/vx_csr_unit_pkg.sv
// Shared types, widths and helpers for the CSR sequencer.
package vx_csr_unit_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned UUID_WIDTH       = 16;
  localparam int unsigned NW_WIDTH         = 2;
  localparam int unsigned NR_BITS          = 5;
  localparam int unsigned VX_CSR_ADDR_BITS = 12;

  // Top two address bits equal to this mark a read-only CSR.
  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    CsrRw  = 2'd0,
    CsrRs  = 2'd1,
    CsrRc  = 2'd2,
    CsrIll = 2'd3
  } csr_op_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]       uuid;
    logic [NW_WIDTH-1:0]         wid;
    csr_op_t                     op;
    logic [XLEN-1:0]             src;
    logic [VX_CSR_ADDR_BITS-1:0] addr;
    logic [NR_BITS-1:0]          rd;
    logic                        wb;
  } csr_req_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NW_WIDTH-1:0]   wid;
    logic [NR_BITS-1:0]    rd;
    logic                  wb;
    logic [XLEN-1:0]       data;
  } csr_rsp_t;

  function automatic logic [XLEN-1:0] csr_new_value(input csr_op_t         op,
                                                    input logic [XLEN-1:0] old_val,
                                                    input logic [XLEN-1:0] src);
    logic [XLEN-1:0] res;
    case (op)
      CsrRs:   res = old_val | src;
      CsrRc:   res = old_val & ~src;
      default: res = src;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/vx_csr_unit_elastic_buffer.sv
// Response elastic buffer: Size 1 is a zero-latency pass-through, Size 2 a registered
// two-entry FIFO that sustains one transfer per cycle.
module vx_csr_unit_elastic_buffer #(
  parameter int unsigned Size      = 2,
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [DataWidth-1:0] data_in,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [DataWidth-1:0] data_out
);

  if (Size == 1) begin : g_pass
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign valid_out = valid_in;
    assign ready_in  = ready_out;
    assign data_out  = data_in;
  end else begin : g_fifo
    logic [DataWidth-1:0] mem_q [2];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           count_q;
    logic                 push, pop;

    assign ready_in  = (count_q != 2'd2);
    assign valid_out = (count_q != 2'd0);
    assign data_out  = mem_q[rd_ptr_q];
    assign push      = valid_in & ready_in;
    assign pop       = valid_out & ready_out;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        mem_q[0] <= '0;
        mem_q[1] <= '0;
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
        count_q  <= 2'd0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= data_in;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + 2'd1;
          2'b01:   count_q <= count_q - 2'd1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: rtl/vx_csr_unit.sv
// CSR instruction sequencer: S0 reads CSR storage, S1 computes/writes the new value and pushes
// the old value into the response buffer. Define CSR_FWD_EN to bypass S1 into S0 on hazards.
module vx_csr_unit
  import vx_csr_unit_pkg::*;
#(
  parameter string       INSTANCE_ID = "",
  parameter int unsigned OUT_BUF     = 2
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [UUID_WIDTH-1:0]       req_uuid,
  input  logic [NW_WIDTH-1:0]         req_wid,
  input  logic [1:0]                  req_op,
  input  logic                        req_use_imm,
  input  logic [4:0]                  req_imm,
  input  logic [XLEN-1:0]             req_rs1_data,
  input  logic                        req_rs1_zero,
  input  logic [VX_CSR_ADDR_BITS-1:0] req_addr,
  input  logic [NR_BITS-1:0]          req_rd,
  input  logic                        req_wb,

  output logic                        read_enable,
  output logic [UUID_WIDTH-1:0]       read_uuid,
  output logic [NW_WIDTH-1:0]         read_wid,
  output logic [VX_CSR_ADDR_BITS-1:0] read_addr,
  input  logic [XLEN-1:0]             read_data_ro,
  input  logic [XLEN-1:0]             read_data_rw,

  output logic                        write_enable,
  output logic [UUID_WIDTH-1:0]       write_uuid,
  output logic [NW_WIDTH-1:0]         write_wid,
  output logic [VX_CSR_ADDR_BITS-1:0] write_addr,
  output logic [XLEN-1:0]             write_data,

  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [UUID_WIDTH-1:0]       rsp_uuid,
  output logic [NW_WIDTH-1:0]         rsp_wid,
  output logic [NR_BITS-1:0]          rsp_rd,
  output logic                        rsp_wb,
  output logic [XLEN-1:0]             rsp_data
);

  csr_req_t        s0_req;
  logic [XLEN-1:0] s0_src, s0_old, s0_read;
  logic            s0_wr_req, s0_ro, s0_fire;

  csr_req_t        s1_req_q, s1_req_d;
  logic [XLEN-1:0] s1_old_q, s1_old_d, s1_new;
  logic            s1_valid_q, s1_valid_d, s1_wr_req_q, s1_wr_req_d;
  logic            s1_fire, hazard;

  csr_rsp_t        s1_rsp, buf_rsp;
  logic            buf_ready;

  // ---------------------------------------------------------------- S0
  assign s0_src  = req_use_imm ? {{(XLEN-5){1'b0}}, req_imm} : req_rs1_data;
  assign s0_ro   = (req_addr[VX_CSR_ADDR_BITS-1 -: 2] == CSR_RO_PREFIX);
  assign s0_read = read_data_ro | read_data_rw;

  always_comb begin
    s0_req      = '0;
    s0_req.uuid = req_uuid;
    s0_req.wid  = req_wid;
    s0_req.op   = csr_op_t'(req_op);
    s0_req.src  = s0_src;
    s0_req.addr = req_addr;
    s0_req.rd   = req_rd;
    s0_req.wb   = req_wb;
  end

  // Set/clear with a zero operand leaves the CSR untouched, so no write is issued.
  always_comb begin
    s0_wr_req = 1'b0;
    if (s0_req.op == CsrRw) begin
      s0_wr_req = 1'b1;
    end else if (s0_req.op != CsrIll) begin
      s0_wr_req = req_use_imm ? (req_imm != 5'd0) : ~req_rs1_zero;
    end
    if (s0_ro) begin
      s0_wr_req = 1'b0;
    end
  end

  assign hazard  = s1_valid_q & s1_wr_req_q & (req_addr == s1_req_q.addr);
  assign s1_fire = s1_valid_q & buf_ready;

`ifdef CSR_FWD_EN
  // A hazard can only be accepted while S1 fires, so S1's new value is what storage will hold.
  assign req_ready = reset & (~s1_valid_q | s1_fire);
  assign s0_old    = hazard ? s1_new : s0_read;
`else
  assign req_ready = reset & (~s1_valid_q | s1_fire) & ~hazard;
  assign s0_old    = s0_read;
`endif

  assign s0_fire     = req_valid & req_ready;
  assign read_enable = s0_fire;
  assign read_uuid   = s0_fire ? req_uuid : '0;
  assign read_wid    = s0_fire ? req_wid : '0;
  assign read_addr   = s0_fire ? req_addr : '0;

  // ---------------------------------------------------------------- S1
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_req_d    = s1_req_q;
    s1_old_d    = s1_old_q;
    s1_wr_req_d = s1_wr_req_q;
    if (s0_fire) begin
      s1_valid_d  = 1'b1;
      s1_req_d    = s0_req;
      s1_old_d    = s0_old;
      s1_wr_req_d = s0_wr_req;
    end else if (s1_fire) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_req_q    <= '0;
      s1_old_q    <= '0;
      s1_wr_req_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_req_q    <= s1_req_d;
      s1_old_q    <= s1_old_d;
      s1_wr_req_q <= s1_wr_req_d;
    end
  end

  assign s1_new = csr_new_value(s1_req_q.op, s1_old_q, s1_req_q.src);

  // Write and buffer push share s1_fire, so each request writes at most once.
  assign write_enable = s1_fire & s1_wr_req_q;
  assign write_uuid   = s1_req_q.uuid;
  assign write_wid    = s1_req_q.wid;
  assign write_addr   = s1_req_q.addr;
  assign write_data   = s1_new;

  // ---------------------------------------------------------------- response
  always_comb begin
    s1_rsp      = '0;
    s1_rsp.uuid = s1_req_q.uuid;
    s1_rsp.wid  = s1_req_q.wid;
    s1_rsp.rd   = s1_req_q.rd;
    s1_rsp.wb   = s1_req_q.wb;
    s1_rsp.data = s1_old_q;
  end

  vx_csr_unit_elastic_buffer #(
    .Size      (OUT_BUF),
    .DataWidth ($bits(csr_rsp_t))
  ) u_rsp_buf (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (s1_valid_q),
    .ready_in  (buf_ready),
    .data_in   (s1_rsp),
    .valid_out (rsp_valid),
    .ready_out (rsp_ready),
    .data_out  (buf_rsp)
  );

  assign rsp_uuid = buf_rsp.uuid;
  assign rsp_wid  = buf_rsp.wid;
  assign rsp_rd   = buf_rsp.rd;
  assign rsp_wb   = buf_rsp.wb;
  assign rsp_data = buf_rsp.data;

  illegal_op_a: assert property (@(posedge clk) disable iff (!reset)
                                 s0_fire |-> (req_op != 2'd3))
    else $error("%s: illegal CSR op, uuid=%0h", INSTANCE_ID, req_uuid);

endmodule

// File: tb/tb_vx_csr_unit.sv
// Scoreboard bench for vx_csr_unit: a CSR storage stub answers reads and absorbs writes,
// directed requests push expected writes/responses, a monitor pops and compares them.
module tb_vx_csr_unit;
  import vx_csr_unit_pkg::*;

  localparam int unsigned OutBuf = 2;
  localparam int ExpLat = (OutBuf == 1) ? 1 : 2;
`ifdef CSR_FWD_EN
  localparam int ExpBubbles = 0;
`else
  localparam int ExpBubbles = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_ready, req_use_imm, req_rs1_zero, req_wb;
  logic [UUID_WIDTH-1:0] req_uuid, read_uuid, write_uuid, rsp_uuid;
  logic [NW_WIDTH-1:0] req_wid, read_wid, write_wid, rsp_wid;
  logic [1:0] req_op;
  logic [4:0] req_imm;
  logic [XLEN-1:0] req_rs1_data, read_data_ro, read_data_rw, write_data, rsp_data;
  logic [VX_CSR_ADDR_BITS-1:0] req_addr, read_addr, write_addr;
  logic [NR_BITS-1:0] req_rd, rsp_rd;
  logic read_enable, write_enable, rsp_valid, rsp_ready, rsp_wb;

  typedef struct {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NW_WIDTH-1:0] wid;
    logic [VX_CSR_ADDR_BITS-1:0] addr;
    logic [XLEN-1:0] data;
  } wr_exp_t;

  typedef struct {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NW_WIDTH-1:0] wid;
    logic [NR_BITS-1:0] rd;
    logic wb;
    logic [XLEN-1:0] data;
    int acc;
    bit chk_lat;
  } rsp_exp_t;

  wr_exp_t  exp_wr[$];
  rsp_exp_t exp_rsp[$];
  int tests = 0;
  int fails = 0;
  int wr_seen = 0;
  int cycle = 0;

  logic [XLEN-1:0] csr_mem [4096] = '{default: '0};
  logic pre_we = 1'b0;
  logic [VX_CSR_ADDR_BITS-1:0] pre_addr = '0;
  logic [XLEN-1:0] pre_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // CSR storage stub
  always @(posedge clk) begin
    if (pre_we) csr_mem[pre_addr] <= pre_data;
    else if (write_enable) csr_mem[write_addr] <= write_data;
  end
  assign read_data_rw = (read_enable && read_addr[11:10] != 2'b11) ? csr_mem[read_addr] : '0;
  assign read_data_ro = (read_enable && read_addr[11:10] == 2'b11) ? csr_mem[read_addr] : '0;

  vx_csr_unit #(.INSTANCE_ID("tb"), .OUT_BUF(OutBuf)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid), .req_wid(req_wid),
    .req_op(req_op), .req_use_imm(req_use_imm), .req_imm(req_imm),
    .req_rs1_data(req_rs1_data), .req_rs1_zero(req_rs1_zero), .req_addr(req_addr),
    .req_rd(req_rd), .req_wb(req_wb),
    .read_enable(read_enable), .read_uuid(read_uuid), .read_wid(read_wid),
    .read_addr(read_addr), .read_data_ro(read_data_ro), .read_data_rw(read_data_rw),
    .write_enable(write_enable), .write_uuid(write_uuid), .write_wid(write_wid),
    .write_addr(write_addr), .write_data(write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid), .rsp_wid(rsp_wid),
    .rsp_rd(rsp_rd), .rsp_wb(rsp_wb), .rsp_data(rsp_data)
  );

  // Monitor: pops expectations whenever the DUT writes or hands over a response.
  initial begin : monitor
    wr_exp_t  we;
    rsp_exp_t re;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (write_enable) begin
          tests++;
          wr_seen++;
          if (exp_wr.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got addr=%h data=%h uuid=%h, required no write",
                     write_addr, write_data, write_uuid);
          end else begin
            we = exp_wr.pop_front();
            if (write_addr !== we.addr || write_data !== we.data || write_uuid !== we.uuid ||
                write_wid !== we.wid) begin
              fails++;
              $display("FAIL write_u%0h: got addr=%h data=%h uuid=%h wid=%0d, required addr=%h data=%h uuid=%h wid=%0d",
                       we.uuid, write_addr, write_data, write_uuid, write_wid,
                       we.addr, we.data, we.uuid, we.wid);
            end
          end
        end
        if (rsp_valid && rsp_ready) begin
          tests++;
          if (exp_rsp.size() == 0) begin
            fails++;
            $display("FAIL unexpected_rsp: got uuid=%h data=%h, required no response",
                     rsp_uuid, rsp_data);
          end else begin
            re = exp_rsp.pop_front();
            if (rsp_uuid !== re.uuid || rsp_wid !== re.wid || rsp_rd !== re.rd ||
                rsp_wb !== re.wb || rsp_data !== re.data) begin
              fails++;
              $display("FAIL rsp_u%0h: got uuid=%h wid=%0d rd=%0d wb=%b data=%h, required uuid=%h wid=%0d rd=%0d wb=%b data=%h",
                       re.uuid, rsp_uuid, rsp_wid, rsp_rd, rsp_wb, rsp_data,
                       re.uuid, re.wid, re.rd, re.wb, re.data);
            end
            if (re.chk_lat) begin
              tests++;
              if (cycle - re.acc != ExpLat) begin
                fails++;
                $display("FAIL latency_u%0h: got %0d cycles, required %0d",
                         re.uuid, cycle - re.acc, ExpLat);
              end
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic preload(input logic [VX_CSR_ADDR_BITS-1:0] addr, input logic [XLEN-1:0] data);
    pre_addr = addr;
    pre_data = data;
    pre_we   = 1'b1;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  // wid/rd/wb are derived from the uuid so passthrough is checked on every request.
  task automatic issue(input logic [UUID_WIDTH-1:0] uuid, input logic [1:0] op,
                       input logic use_imm, input logic [4:0] imm, input logic [XLEN-1:0] rs1,
                       input logic rs1_zero, input logic [VX_CSR_ADDR_BITS-1:0] addr,
                       input logic exp_we, input logic [XLEN-1:0] exp_wdata,
                       input logic [XLEN-1:0] exp_old, input bit chk_lat, output int acc);
    int n;
    wr_exp_t  we;
    rsp_exp_t re;
    req_uuid     = uuid;
    req_wid      = uuid[NW_WIDTH-1:0];
    req_op       = op;
    req_use_imm  = use_imm;
    req_imm      = imm;
    req_rs1_data = rs1;
    req_rs1_zero = rs1_zero;
    req_addr     = addr;
    req_rd       = uuid[NR_BITS-1:0] + 5'd1;
    req_wb       = ~uuid[0];
    req_valid    = 1'b1;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cycle;
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout_u%0h: got req_ready=0, required 1", uuid);
    end else begin
      if (exp_we) begin
        we.uuid = uuid;
        we.wid  = uuid[NW_WIDTH-1:0];
        we.addr = addr;
        we.data = exp_wdata;
        exp_wr.push_back(we);
      end
      re.uuid    = uuid;
      re.wid     = uuid[NW_WIDTH-1:0];
      re.rd      = uuid[NR_BITS-1:0] + 5'd1;
      re.wb      = ~uuid[0];
      re.data    = exp_old;
      re.acc     = cycle;
      re.chk_lat = chk_lat;
      exp_rsp.push_back(re);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_rsp.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int a1, a2, base;
    reset        = 1'b0;
    req_valid    = 1'b1;
    req_uuid     = '0;
    req_wid      = '0;
    req_op       = 2'd0;
    req_use_imm  = 1'b0;
    req_imm      = '0;
    req_rs1_data = 32'h1;
    req_rs1_zero = 1'b0;
    req_addr     = 12'h340;
    req_rd       = '0;
    req_wb       = 1'b0;
    rsp_ready    = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_read_enable", {31'd0, read_enable}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_write_enable", {31'd0, write_enable}, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;

    // CSRRW mscratch, also checks accept-to-response latency
    preload(12'h340, 32'hA5);
    issue(16'h0001, 2'd0, 1'b0, 5'd0, 32'h1234, 1'b0, 12'h340, 1'b1, 32'h1234, 32'hA5, 1'b1, a1);
    drain();
    // CSRRS x0 on mcycle: read only, no write
    preload(12'hB00, 32'h777);
    issue(16'h0002, 2'd1, 1'b0, 5'd0, 32'h0, 1'b1, 12'hB00, 1'b0, 32'h0, 32'h777, 1'b0, a1);
    drain();
    // CSRRW to read-only space: no write
    preload(12'hC00, 32'h55);
    issue(16'h0003, 2'd0, 1'b0, 5'd0, 32'hFF, 1'b0, 12'hC00, 1'b0, 32'h0, 32'h55, 1'b0, a1);
    drain();
    // CSRRCI 3 on fflags
    preload(12'h001, 32'h1F);
    issue(16'h0004, 2'd2, 1'b1, 5'd3, 32'hFFFF, 1'b0, 12'h001, 1'b1, 32'h1C, 32'h1F, 1'b0, a1);
    drain();
    // CSRRS register form, CSRRSI with zero immediate
    preload(12'h300, 32'h8);
    issue(16'h0005, 2'd1, 1'b0, 5'd0, 32'hF0, 1'b0, 12'h300, 1'b1, 32'hF8, 32'h8, 1'b0, a1);
    issue(16'h0006, 2'd1, 1'b1, 5'd0, 32'hFF, 1'b0, 12'h340, 1'b0, 32'h0, 32'h1234, 1'b0, a1);
    drain();

    // back-to-back CSRRS on the same CSR
    preload(12'h340, 32'h0);
    issue(16'h0010, 2'd1, 1'b0, 5'd0, 32'h1, 1'b0, 12'h340, 1'b1, 32'h1, 32'h0, 1'b0, a1);
    issue(16'h0011, 2'd1, 1'b0, 5'd0, 32'h2, 1'b0, 12'h340, 1'b1, 32'h3, 32'h1, 1'b0, a2);
    check("b2b_bubbles", a2 - a1 - 1, ExpBubbles);
    drain();

    // backpressure: three requests held behind rsp_ready=0
    preload(12'h341, 32'h10);
    preload(12'h342, 32'h20);
    preload(12'h343, 32'h30);
    rsp_ready = 1'b0;
    base = wr_seen;
    issue(16'h0021, 2'd0, 1'b0, 5'd0, 32'hA1, 1'b0, 12'h341, 1'b1, 32'hA1, 32'h10, 1'b0, a1);
    issue(16'h0022, 2'd1, 1'b0, 5'd0, 32'hA2, 1'b0, 12'h342, 1'b1, 32'hA2, 32'h20, 1'b0, a1);
    issue(16'h0023, 2'd2, 1'b0, 5'd0, 32'h10, 1'b0, 12'h343, 1'b1, 32'h20, 32'h30, 1'b0, a1);
    repeat (5) @(posedge clk);
    #1;
    check("bp_writes_held", wr_seen - base, 32'd2);
    check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    drain();
    check("bp_writes_total", wr_seen - base, 32'd3);

    // reset with buffer full and S1 holding a pending write
    preload(12'h346, 32'h99);
    rsp_ready = 1'b0;
    issue(16'h0031, 2'd0, 1'b0, 5'd0, 32'h11, 1'b0, 12'h344, 1'b1, 32'h11, 32'h0, 1'b0, a1);
    issue(16'h0032, 2'd0, 1'b0, 5'd0, 32'h22, 1'b0, 12'h345, 1'b1, 32'h22, 32'h0, 1'b0, a1);
    issue(16'h0033, 2'd0, 1'b0, 5'd0, 32'h33, 1'b0, 12'h346, 1'b0, 32'h0, 32'h99, 1'b0, a1);
    @(negedge clk);
    check("stall_write_enable", {31'd0, write_enable}, 32'd0);
    check("stall_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_rsp.delete();
    repeat (2) begin
      @(negedge clk);
      check("midrst_write_enable", {31'd0, write_enable}, 32'd0);
      check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    reset     = 1'b1;
    rsp_ready = 1'b1;
    issue(16'h0034, 2'd0, 1'b0, 5'd0, 32'h44, 1'b0, 12'h346, 1'b1, 32'h44, 32'h99, 1'b1, a1);
    drain();

    check("exp_wr_empty", exp_wr.size(), 32'd0);
    check("exp_rsp_empty", exp_rsp.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
